// File: rtl/load_store_unit_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for the load/store unit.
package load_store_unit_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op != MEM_NONE) && (is_load(op) || is_store(op));
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lsb);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lsb[0];
            MEM_LW, MEM_SW:          return |lsb;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [3:0] op, input logic [1:0] lsb);
        case (op)
            MEM_SB:  return 4'b0001 << lsb;
            MEM_SH:  return lsb[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] data);
        case (op)
            MEM_SB:  return {4{data[7:0]}};
            MEM_SH:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane select and sign/zero extension (combinational).
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lsb,
    input  logic [3:0]  op,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lsb)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lsb[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (op)
            MEM_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: value = {24'd0, byte_sel};
            MEM_LH:  value = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/gnt/rvalid data port, load alignment, one writeback beat per op.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
//
// state   | meaning
// IDLE    | ready to accept an instruction
// REQ     | bus request held until dmem_gnt
// WAIT    | load granted, waiting for dmem_rvalid
// RESP    | writeback beat held until wb_ready
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [3:0]            mem_op,
    input  logic [XLEN-1:0]       addr,
    input  logic [XLEN-1:0]       store_data,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [3:0]            dmem_wstrb,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  misaligned
);

    lsu_state_e      state_q, state_d;
    logic [3:0]      op_q;
    logic [1:0]      lsb_q;
    logic [XLEN-1:0] load_value;
    logic            accept, fault_in, go_req;

`ifdef MISALIGN_TRAP_EN
    logic misaligned_q;
    assign fault_in   = is_misaligned(mem_op, addr[1:0]);
    assign misaligned = misaligned_q;

    always_ff @(posedge clk) begin
        if (rst)
            misaligned_q <= 1'b0;
        else if (accept)
            misaligned_q <= fault_in;
    end
`else
    assign fault_in   = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign accept = ex_valid && ex_ready;
    assign go_req = is_mem(mem_op) && !fault_in;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ex_valid)    state_d = go_req ? ST_REQ : ST_RESP;
            ST_REQ:  if (dmem_gnt)    state_d = is_load(op_q) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (dmem_rvalid) state_d = ST_RESP;
            ST_RESP: if (wb_ready)    state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ex_ready = (state_q == ST_IDLE);
        dmem_req = (state_q == ST_REQ);
        wb_valid = (state_q == ST_RESP);
    end

    load_store_unit_align u_load_align (
        .rdata (dmem_rdata),
        .lsb   (lsb_q),
        .op    (op_q),
        .value (load_value)
    );

    // Bus fields are loaded once at accept so they stay put for the whole REQ phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= MEM_NONE;
            lsb_q      <= 2'd0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wstrb <= 4'b0000;
            dmem_wdata <= '0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            if (accept) begin
                op_q      <= mem_op;
                lsb_q     <= addr[1:0];
                dmem_addr <= {addr[XLEN-1:2], 2'b00};
                wb_rd     <= rd_in;
                wb_data   <= addr;
                wb_we     <= !fault_in && !is_store(mem_op);
                if (go_req) begin
                    dmem_we    <= is_store(mem_op);
                    dmem_wstrb <= store_strobe(mem_op, addr[1:0]);
                    dmem_wdata <= store_lanes(mem_op, store_data);
                end else begin
                    dmem_we    <= 1'b0;
                    dmem_wstrb <= 4'b0000;
                end
            end
            if (state_q == ST_WAIT && dmem_rvalid)
                wb_data <= load_value;
        end
    end

endmodule
